moore_step_counter: RTL and testbench
=====================================

// Module: moore_step_counter
// PURPOSE
//   Parametrised Moore step counter: a modulo-N state register that advances one
//   state per accepted step request, either up or down. Supports wrap or saturate
//   limits, level or rising-edge step detection, synchronous load and a one-cycle
//   wrap/limit event flag. Generalises the fixed 3-state mod-3 step machine for
//   datapath sequencing and the lab display counters.
// PARAMETERS
//   N_STATES   3   number of states, >= 2; legal state values are 0..N_STATES-1
//   W          2   state width; must satisfy 2**W >= N_STATES
//   SATURATE   0   0: wrap at limits; 1: hold at limits
//   EDGE_MODE  0   0: step on in==1 each cycle; 1: step only on rising edge of in
//   INIT       0   reset and recovery state; must be < N_STATES
// PORTS
//   clk        in   1   clock; all state changes on its rising edge
//   rst        in   1   synchronous, active-high reset
//   in         in   1   step request
//   dir        in   1   1 = count up, 0 = count down; sampled with the step
//   load       in   1   synchronous load strobe
//   load_val   in   W   value for load
//   state_out  out  W   current state (registered; Moore output)
//   wrap       out  1   one-cycle pulse: a limit was crossed or hit on the last step
//   at_max     out  1   state_out == N_STATES-1 (decoded from state only)
//   at_min     out  1   state_out == 0 (decoded from state only)
// BEHAVIOUR
//   - Reset (rst=1 at the clock edge): state=INIT, wrap=0, in_d=0. at_max and
//     at_min follow the decoded INIT value. rst overrides load and step.
//   - step = EDGE_MODE ? (in & ~in_d) : in. in_d is a register of in, updated
//     every non-reset cycle. An in held high through reset release counts as one
//     edge on the first cycle after reset.
//   - Priority per edge: rst > load > step > hold.
//   - load=1: state <= (load_val >= N_STATES) ? N_STATES-1 : load_val; wrap <= 0;
//     any concurrent step is discarded. In EDGE_MODE, in_d still updates.
//   - Step up:
//     - If state < N_STATES-1: state+1.
//     - At N_STATES-1: 0 when SATURATE=0, hold when SATURATE=1; wrap <= 1 in both cases.
//   - Step down:
//     - If state > 0: state-1.
//     - At 0: N_STATES-1 when SATURATE=0, hold when SATURATE=1; wrap <= 1.
//   - No step, or a step that is not at a limit: wrap <= 0. wrap is never high
//     for two consecutive cycles unless a limit step occurs on consecutive cycles.
//   - Latency: a step or load sampled at edge k is visible on state_out and wrap
//     after edge k. at_max and at_min change in the same cycle as state_out.
//   - Arithmetic is W bits with no intermediate overflow. Comparisons use
//     N_STATES-1 as a W-bit constant.
//   - Out-of-range state (>= N_STATES, unreachable in normal operation): next
//     state = INIT on the following edge regardless of inputs except rst/load;
//     wrap <= 0.
//   - The next-state logic must be fully specified (default branch) so that no
//     latches are inferred.
// TESTING
//   Use defaults (N=3, W=2, wrap, level mode) unless stated otherwise.
//   1. Reset and up-count: rst=1 for 2 cycles, then in=1, dir=1 for 4 cycles.
//      -> state_out 0,1,2,0,1; wrap=1 only in the cycle state_out becomes 0;
//      at_max=1 while state_out=2.
//   2. Down-wrap: from state 0, in=1, dir=0 for 1 cycle.
//      -> state_out=2, wrap=1 for one cycle, then 0.
//   3. Saturation (SATURATE=1): count up to 2, then hold in=1, dir=1 for 3 cycles.
//      -> state_out stays 2; wrap=1 for each of the 3 cycles. Down at 0 behaves
//      the same way.
//   4. Edge mode (EDGE_MODE=1): in high for 5 cycles, low for 1, high for 1.
//      -> exactly 2 increments, 0->1->2; no increments during the held-high cycles.
//   5. Load and clamp (N=5, W=3): load=1, load_val=7 with in=1 in the same cycle.
//      -> state_out=4, wrap=0, step ignored. Then load_val=2 -> state_out=2.
//   6. Mid-operation reset: in state 2 with in=1, assert rst for 1 cycle.
//      -> state_out=INIT(0), wrap=0 after that edge, and counting resumes from 0.

Source files
------------

// File: rtl/moore_step_counter.sv
// rtl/moore_step_counter.sv - modulo-N up/down step counter with wrap/saturate, edge detect and load
module moore_step_counter #(
  parameter int N_STATES  = 3,
  parameter int W         = 2,
  parameter int SATURATE  = 0,
  parameter int EDGE_MODE = 0,
  parameter int INIT      = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state_out,
  output logic         wrap,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MAX_S  = W'(N_STATES - 1);
  localparam logic [W-1:0] INIT_S = W'(INIT);
  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] ZERO   = '0;

  logic [W-1:0] state_q, state_d;
  logic         wrap_q, wrap_d;
  logic         in_d;
  logic         step;

  // State, event flag and input-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_S;
      wrap_q  <= 1'b0;
      in_d    <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      in_d    <= in;
    end
  end

  // Next state: load beats step; an illegal state recovers to INIT; limits wrap or hold
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    step    = (EDGE_MODE != 0) ? (in & ~in_d) : in;
    if (load) begin
      state_d = (load_val > MAX_S) ? MAX_S : load_val;
    end else if (state_q > MAX_S) begin
      state_d = INIT_S;
    end else if (step) begin
      if (dir) begin
        if (state_q == MAX_S) begin
          wrap_d  = 1'b1;
          state_d = (SATURATE != 0) ? MAX_S : ZERO;
        end else begin
          state_d = state_q + ONE;
        end
      end else begin
        if (state_q == ZERO) begin
          wrap_d  = 1'b1;
          state_d = (SATURATE != 0) ? ZERO : MAX_S;
        end else begin
          state_d = state_q - ONE;
        end
      end
    end
  end

  assign state_out = state_q;
  assign wrap      = wrap_q;
  assign at_max    = (state_q == MAX_S);
  assign at_min    = (state_q == ZERO);

endmodule

// File: tb/tb_moore_step_counter.sv
// tb/tb_moore_step_counter.sv - scoreboard bench over four counter configurations
module tb_moore_step_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;

  logic [1:0] s0, s1, s2;
  logic [2:0] s3;
  logic [3:0] w, amax, amin;

  int compared = 0;
  int mismatched = 0;

  // configurations: default, saturating, edge-triggered, N=5/W=3
  int cfg_n[4]   = '{3, 3, 3, 5};
  int cfg_sat[4] = '{0, 1, 0, 0};
  int cfg_edg[4] = '{0, 0, 1, 0};

  int m_s[4];
  bit m_ind[4];
  bit m_w[4];

  logic [15:0] sb[$];

  always #5 clk = ~clk;

  moore_step_counter #(.N_STATES(3), .W(2), .SATURATE(0), .EDGE_MODE(0), .INIT(0)) u_def (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .load(load), .load_val(load_val[1:0]),
    .state_out(s0), .wrap(w[0]), .at_max(amax[0]), .at_min(amin[0]));
  moore_step_counter #(.N_STATES(3), .W(2), .SATURATE(1), .EDGE_MODE(0), .INIT(0)) u_sat (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .load(load), .load_val(load_val[1:0]),
    .state_out(s1), .wrap(w[1]), .at_max(amax[1]), .at_min(amin[1]));
  moore_step_counter #(.N_STATES(3), .W(2), .SATURATE(0), .EDGE_MODE(1), .INIT(0)) u_edg (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .load(load), .load_val(load_val[1:0]),
    .state_out(s2), .wrap(w[2]), .at_max(amax[2]), .at_min(amin[2]));
  moore_step_counter #(.N_STATES(5), .W(3), .SATURATE(0), .EDGE_MODE(0), .INIT(0)) u_n5 (
    .clk(clk), .rst(rst), .in(in), .dir(dir), .load(load), .load_val(load_val),
    .state_out(s3), .wrap(w[3]), .at_max(amax[3]), .at_min(amin[3]));

  task automatic check(input string name, input int k, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s[cfg%0d] t=%0t actual=%0d required=%0d", name, k, $time, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; after the edge, advance the reference and queue expectations
  task automatic drive(input bit r, input bit i, input bit d, input bit l, input int lv);
    logic [15:0] e;
    rst = r; in = i; dir = d; load = l; load_val = 3'(lv);
    @(posedge clk);
    e = '0;
    for (int k = 0; k < 4; k++) begin
      int n, v;
      bit st, lim;
      n = cfg_n[k];
      v = (n == 5) ? (lv % 8) : (lv % 4);
      if (r) begin
        m_s[k] = 0; m_w[k] = 0; m_ind[k] = 0;
      end else begin
        st = cfg_edg[k] ? (i && !m_ind[k]) : i;
        m_ind[k] = i;
        m_w[k] = 0;
        if (l) begin
          m_s[k] = (v >= n) ? n - 1 : v;
        end else if (st) begin
          lim = d ? (m_s[k] == n - 1) : (m_s[k] == 0);
          m_w[k] = lim;
          if (!(lim && cfg_sat[k]))
            m_s[k] = (m_s[k] + (d ? 1 : n - 1)) % n;
        end
      end
      e[k*4 +: 4] = {3'(m_s[k]), m_w[k]};
    end
    sb.push_back(e);
    #1;
  endtask

  // Monitor: every queued expectation is compared against the outputs one half-cycle after its edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [15:0] e;
      int act_s[4];
      int es;
      e = sb.pop_front();
      act_s[0] = s0; act_s[1] = s1; act_s[2] = s2; act_s[3] = s3;
      for (int k = 0; k < 4; k++) begin
        es = e[k*4+1 +: 3];
        check("state_out", k, act_s[k], es);
        check("wrap", k, w[k], e[k*4]);
        check("at_max", k, amax[k], es == cfg_n[k] - 1);
        check("at_min", k, amin[k], es == 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset then up-count (saturation and single-edge behaviour observed on the other instances)
    drive(1, 0, 1, 0, 0); drive(1, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) drive(0, 1, 1, 0, 0);
    // down-wrap from 0, then saturate at 0
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // edge mode pattern: high 5, low 1, high 1
    drive(1, 0, 1, 0, 0);
    for (int c = 0; c < 5; c++) drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0); drive(0, 1, 1, 0, 0); drive(0, 0, 1, 0, 0);
    // load clamp with concurrent step, then in-range load
    drive(0, 1, 1, 1, 7); drive(0, 0, 1, 1, 2); drive(0, 0, 1, 0, 0);
    // mid-operation reset with in held high across release
    drive(0, 1, 1, 1, 2); drive(1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0); drive(0, 1, 1, 0, 0);
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 7));
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
